// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg: scan codes, state encodings and key mapping shared by the PS/2 decoder
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_F     = 8'h2B;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;
    localparam int KEY_F     = 5;
    localparam int NUM_KEYS  = 6;

    typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} dec_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    // One-hot held-vector mask for a code; arrows only map when extended, enter/f only when not.
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code, input logic ext);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (ext) begin
            m[KEY_UP]    = (code == SC_UP);
            m[KEY_DOWN]  = (code == SC_DOWN);
            m[KEY_LEFT]  = (code == SC_LEFT);
            m[KEY_RIGHT] = (code == SC_RIGHT);
        end else begin
            m[KEY_ENTER] = (code == SC_ENTER);
            m[KEY_F]     = (code == SC_F);
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// ps2_frame_rx: synchronizes the PS/2 pins and assembles 11-bit frames with parity, stop and timeout checks
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frameError,
    output logic       abort
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    rx_state_t     state;
    rx_state_t     state_n;
    logic [3:0]    cnt;
    logic [7:0]    shift;
    logic          parity;
    logic [TW-1:0] timer;
    logic          done;
    logic          timeout;
    logic          good;

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];
    assign good   = bit_in & (^{shift, parity});

    // Two-flop synchronizers plus the previous-clock flop used for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_n;
    end

    // A low start bit opens a frame; the stop-bit edge or a stalled clock closes it
    always_comb begin
        state_n = state;
        done    = 1'b0;
        timeout = 1'b0;
        if (state == RX_IDLE) begin
            state_n = (fall && !bit_in) ? RX_RECV : RX_IDLE;
        end else if (fall && cnt == 4'd10) begin
            state_n = RX_IDLE;
            done    = 1'b1;
        end else if (!fall && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = RX_IDLE;
            timeout = 1'b1;
        end
    end

    // Bit counter, data shifter, timeout counter and registered result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            timer      <= '0;
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            frameError <= 1'b0;
            abort      <= 1'b0;
        end else begin
            cnt        <= (state_n == RX_IDLE) ? 4'd0 : fall ? cnt + 4'd1 : cnt;
            shift      <= (fall && cnt >= 4'd1 && cnt <= 4'd8) ? {bit_in, shift[7:1]} : shift;
            parity     <= (fall && cnt == 4'd9) ? bit_in : parity;
            timer      <= (state == RX_IDLE || fall) ? '0 : timer + 1'b1;
            rx_valid   <= done & good;
            rx_byte    <= done ? shift : rx_byte;
            frameError <= (done & ~good) | timeout;
            abort      <= timeout;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 make/break sequences into one-shot key-press pulses
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic upPressed,
    output logic downPressed,
    output logic leftPressed,
    output logic rightPressed,
    output logic enterPressed,
    output logic fPressed,
    output logic frameError
);

    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                abort;
    dec_state_t          state;
    dec_state_t          state_n;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] held_n;
    logic [NUM_KEYS-1:0] pulse;
    logic [NUM_KEYS-1:0] pulse_n;
    logic [NUM_KEYS-1:0] mask;
    logic                prefix;
    logic                ext;
    logic                brk;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .frameError (frameError),
        .abort      (abort)
    );

    assign ext    = (state == EXT) || (state == EXT_BRK);
    assign brk    = (state == BRK) || (state == EXT_BRK);
    assign prefix = ((state == BASE) || (state == EXT)) && ((rx_byte == SC_EXT) || (rx_byte == SC_BREAK));
    assign mask   = key_mask(rx_byte, ext);

    // Prefix state, held keys and output pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BASE;
            held  <= '0;
            pulse <= '0;
        end else begin
            state <= state_n;
            held  <= held_n;
            pulse <= pulse_n;
        end
    end

    // Prefix bytes steer the state; other bytes are classified, and makes of already-held keys are typematic repeats
    always_comb begin
        state_n = state;
        held_n  = held;
        pulse_n = '0;
        if (abort) begin
            state_n = BASE;
        end else if (rx_valid) begin
            if (prefix) begin
                state_n = (rx_byte == SC_BREAK) ? ((state == EXT) ? EXT_BRK : BRK) : EXT;
            end else begin
                state_n = BASE;
                held_n  = brk ? (held & ~mask) : (held | mask);
                pulse_n = brk ? '0 : (mask & ~held);
            end
        end
    end

    assign upPressed    = pulse[KEY_UP];
    assign downPressed  = pulse[KEY_DOWN];
    assign leftPressed  = pulse[KEY_LEFT];
    assign rightPressed = pulse[KEY_RIGHT];
    assign enterPressed = pulse[KEY_ENTER];
    assign fPressed     = pulse[KEY_F];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frame scenarios with hand-computed pulse counts and latency
module tb_ps2_key_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic upPressed, downPressed, leftPressed, rightPressed, enterPressed, fPressed, frameError;
    logic [6:0] outs;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int enter_cyc = 0;
    int n_up = 0, n_down = 0, n_left = 0, n_right = 0, n_enter = 0, n_f = 0, n_err = 0, n_excl = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .upPressed    (upPressed),
        .downPressed  (downPressed),
        .leftPressed  (leftPressed),
        .rightPressed (rightPressed),
        .enterPressed (enterPressed),
        .fPressed     (fPressed),
        .frameError   (frameError)
    );

    assign outs = {frameError, fPressed, enterPressed, rightPressed, leftPressed, downPressed, upPressed};

    always #5 clk = ~clk;

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of every output and any mutual-exclusion breach
    always @(negedge clk) begin
        if (!reset) begin
            n_up    += int'(upPressed);
            n_down  += int'(downPressed);
            n_left  += int'(leftPressed);
            n_right += int'(rightPressed);
            n_enter += int'(enterPressed);
            n_f     += int'(fPressed);
            n_err   += int'(frameError);
            if (enterPressed) enter_cyc = cyc;
            if ($countones(outs) > 1) n_excl++;
        end
    end

    // Drive the first nbits of a frame; each bit set up 5 cycles before the falling edge
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = f[i];
            repeat (5) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (5) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset;
        repeat (4) @(posedge clk);
        @(negedge clk);
        compared++;
        if (outs !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b need %b", outs, 7'b0);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_enter;
        int e0, o0;
        e0 = n_enter;
        o0 = n_up + n_down + n_left + n_right + n_f + n_err;
        send_frame(8'h5A, 0, 11);
        compared++;
        if (n_enter - e0 !== 1) begin
            mismatched++;
            $display("FAIL enter_count: got %0d need 1", n_enter - e0);
        end
        compared++;
        if (enter_cyc - stop_cyc !== 4) begin
            mismatched++;
            $display("FAIL enter_latency: got %0d need 4", enter_cyc - stop_cyc);
        end
        compared++;
        if (n_up + n_down + n_left + n_right + n_f + n_err - o0 !== 0) begin
            mismatched++;
            $display("FAIL enter_others: got %0d need 0", n_up + n_down + n_left + n_right + n_f + n_err - o0);
        end
    endtask

    task automatic test_typematic;
        int u0, o0;
        u0 = n_up;
        o0 = n_down + n_left + n_right + n_enter + n_f + n_err;
        for (int i = 0; i < 6; i++) begin
            send_frame(8'hE0, 0, 11);
            send_frame(8'h75, 0, 11);
        end
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h75, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'h75, 0, 11);
        compared++;
        if (n_up - u0 !== 2) begin
            mismatched++;
            $display("FAIL up_count: got %0d need 2", n_up - u0);
        end
        compared++;
        if (n_down + n_left + n_right + n_enter + n_f + n_err - o0 !== 0) begin
            mismatched++;
            $display("FAIL up_others: got %0d need 0", n_down + n_left + n_right + n_enter + n_f + n_err - o0);
        end
    endtask

    task automatic test_parity;
        int f0, e0;
        f0 = n_f;
        e0 = n_err;
        send_frame(8'h2B, 1, 11);
        compared++;
        if (n_err - e0 !== 1) begin
            mismatched++;
            $display("FAIL parity_error: got %0d need 1", n_err - e0);
        end
        compared++;
        if (n_f - f0 !== 0) begin
            mismatched++;
            $display("FAIL parity_f_blocked: got %0d need 0", n_f - f0);
        end
        send_frame(8'h2B, 0, 11);
        compared++;
        if (n_f - f0 !== 1) begin
            mismatched++;
            $display("FAIL parity_f_after: got %0d need 1", n_f - f0);
        end
    endtask

    task automatic test_extended;
        int l0, r0, o0;
        l0 = n_left;
        r0 = n_right;
        o0 = n_up + n_down + n_enter + n_f + n_err;
        send_frame(8'hE0, 0, 11);
        send_frame(8'h6B, 0, 11);
        send_frame(8'h6B, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'h74, 0, 11);
        compared++;
        if (n_left - l0 !== 1) begin
            mismatched++;
            $display("FAIL left_count: got %0d need 1", n_left - l0);
        end
        compared++;
        if (n_right - r0 !== 1) begin
            mismatched++;
            $display("FAIL right_count: got %0d need 1", n_right - r0);
        end
        compared++;
        if (n_up + n_down + n_enter + n_f + n_err - o0 !== 0) begin
            mismatched++;
            $display("FAIL extended_others: got %0d need 0", n_up + n_down + n_enter + n_f + n_err - o0);
        end
    endtask

    task automatic test_timeout;
        int d0, e0;
        d0 = n_down;
        e0 = n_err;
        send_frame(8'hE0, 0, 11);
        send_frame(8'h72, 0, 5);
        repeat (150) @(posedge clk);
        compared++;
        if (n_err - e0 !== 1) begin
            mismatched++;
            $display("FAIL timeout_error: got %0d need 1", n_err - e0);
        end
        send_frame(8'h72, 0, 11);
        compared++;
        if (n_down - d0 !== 0) begin
            mismatched++;
            $display("FAIL timeout_plain_72: got %0d need 0", n_down - d0);
        end
        send_frame(8'hE0, 0, 11);
        send_frame(8'h72, 0, 11);
        compared++;
        if (n_down - d0 !== 1) begin
            mismatched++;
            $display("FAIL timeout_down: got %0d need 1", n_down - d0);
        end
    endtask

    task automatic test_mid_reset;
        int n0, e0;
        n0 = n_enter;
        e0 = n_err;
        send_frame(8'h5A, 0, 5);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        compared++;
        if (outs !== 7'b0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got %b need %b", outs, 7'b0);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (200) @(posedge clk);
        compared++;
        if ((n_enter - n0) + (n_err - e0) !== 0) begin
            mismatched++;
            $display("FAIL midreset_quiet: got %0d need 0", (n_enter - n0) + (n_err - e0));
        end
        send_frame(8'h5A, 0, 11);
        compared++;
        if (n_enter - n0 !== 1) begin
            mismatched++;
            $display("FAIL midreset_held_cleared: got %0d need 1", n_enter - n0);
        end
    endtask

    task automatic test_exclusion;
        compared++;
        if (n_excl !== 0) begin
            mismatched++;
            $display("FAIL exclusion: got %0d need 0", n_excl);
        end
    endtask

    initial begin
        test_reset;
        test_enter;
        test_typematic;
        test_parity;
        test_extended;
        test_timeout;
        test_mid_reset;
        test_exclusion;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
